sdram_port_arbiter: RTL and testbench

- N-master Avalon-MM arbiter in front of the single-port SDRAM controller.
- Replaces the static reset-selected two-way mux with runtime round-robin arbitration between single-beat masters (burst-converted CPU bus, SD driver, future DMA/VGA ports).
- Routes pipelined read returns back to the issuing master by tracking outstanding reads in an ID FIFO.
- Sits between the per-master burst converters and the SDRAM controller in clk_sys domain.

---
 rtl/sdram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin arbiter that shares the single-port SDRAM
// controller between several single-beat Avalon-MM masters, and steers each
// pipelined read return back to the master that issued it.
module sdram_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IADDR       = 32,
  parameter int OADDR       = 25,
  parameter int MAX_PENDING = 8,
  parameter int IDW         = 3
) (
  input  logic                               clk_sys,
  input  logic                               rst,
  input  logic [NUM_MASTERS*IADDR-1:0]       m_address,
  input  logic [NUM_MASTERS*4-1:0]           m_byteenable,
  input  logic [NUM_MASTERS-1:0]             m_read,
  input  logic [NUM_MASTERS-1:0]             m_write,
  input  logic [NUM_MASTERS*32-1:0]          m_writedata,
  output logic [NUM_MASTERS*32-1:0]          m_readdata,
  output logic [NUM_MASTERS-1:0]             m_readdatavalid,
  output logic [NUM_MASTERS-1:0]             m_waitrequest,
  output logic [OADDR-1:0]                   sdram_address,
  output logic [3:0]                         sdram_byteenable,
  output logic                               sdram_read,
  output logic                               sdram_write,
  output logic [31:0]                        sdram_writedata,
  input  logic [31:0]                        sdram_readdata,
  input  logic                               sdram_readdatavalid,
  input  logic                               sdram_waitrequest,
  output logic [$clog2(MAX_PENDING):0]       pending_count,
  output logic                               err_orphan_rdv
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] fifo_q [MAX_PENDING];
  logic [IDW-1:0] fifo_d [MAX_PENDING];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           err_q, err_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   sel_valid;
  logic [IDW-1:0]         sel;
  logic                   active;
  logic                   sel_read;
  logic                   sel_write;
  logic                   blocked;
  logic                   fwd;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic [IDW-1:0]         head;

  // Pick the granted master: the locked one while a stalled command is held,
  // otherwise the first requester after the last grant in round-robin order.
  always_comb begin
    req       = m_read | m_write;
    sel_valid = 1'b0;
    sel       = '0;
    if (lock_q) begin
      sel       = lock_id_q;
      sel_valid = req[lock_id_q];
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        if (!sel_valid && req[(int'(rr_ptr_q) + k) % NUM_MASTERS]) begin
          sel_valid = 1'b1;
          sel       = IDW'((int'(rr_ptr_q) + k) % NUM_MASTERS);
        end
      end
    end
  end

  // Classify the granted command; a read is held back while the ID FIFO is full.
  always_comb begin
    active    = sel_valid & ~rst;
    sel_write = m_write[sel];
    sel_read  = m_read[sel] & ~m_write[sel];
    blocked   = active & sel_read & (count_q == CW'(MAX_PENDING));
    fwd       = active & ~blocked;
    accept    = fwd & ~sdram_waitrequest;
    push      = accept & sel_read;
    pop       = sdram_readdatavalid & (count_q != '0) & ~rst;
    head      = fifo_q[rd_ptr_q];
  end

  // Drive the controller with the granted master's command and route returns.
  always_comb begin
    sdram_address    = m_address[int'(sel)*IADDR + 2 +: OADDR];
    sdram_byteenable = m_byteenable[int'(sel)*4 +: 4];
    sdram_writedata  = m_writedata[int'(sel)*32 +: 32];
    sdram_read       = fwd & sel_read;
    sdram_write      = fwd & sel_write;
    m_waitrequest    = '1;
    if (active) begin
      m_waitrequest[sel] = sdram_waitrequest | blocked;
    end
    m_readdatavalid = '0;
    m_readdata      = '0;
    if (pop) begin
      m_readdatavalid[head]            = 1'b1;
      m_readdata[int'(head)*32 +: 32]  = sdram_readdata;
    end
    pending_count  = count_q;
    err_orphan_rdv = err_q;
  end

  // Next-state for grant pointer, stall lock, return-ID FIFO and orphan flag.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    if (accept) begin
      rr_ptr_d = sel;
      lock_d   = 1'b0;
    end else if (fwd) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end else if (lock_q && !sel_valid) begin
      lock_d = 1'b0;
    end
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (sdram_readdatavalid && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // State registers; reset discards every outstanding read ID.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      rr_ptr_q  <= IDW'(NUM_MASTERS - 1);
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      for (int i = 0; i < MAX_PENDING; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized masters and controller against a queue-based
// reference model; a negedge monitor compares the DUT with the expectations.
module tb_sdram_port_arbiter;

  localparam int NM    = 3;
  localparam int IADDR = 32;
  localparam int OADDR = 25;
  localparam int MAXP  = 8;
  localparam int IDW   = 3;
  localparam int CW    = $clog2(MAXP) + 1;

  logic                  clk_sys;
  logic                  rst;
  logic [NM*IADDR-1:0]   m_address;
  logic [NM*4-1:0]       m_byteenable;
  logic [NM-1:0]         m_read;
  logic [NM-1:0]         m_write;
  logic [NM*32-1:0]      m_writedata;
  logic [NM*32-1:0]      m_readdata;
  logic [NM-1:0]         m_readdatavalid;
  logic [NM-1:0]         m_waitrequest;
  logic [OADDR-1:0]      sdram_address;
  logic [3:0]            sdram_byteenable;
  logic                  sdram_read;
  logic                  sdram_write;
  logic [31:0]           sdram_writedata;
  logic [31:0]           sdram_readdata;
  logic                  sdram_readdatavalid;
  logic                  sdram_waitrequest;
  logic [CW-1:0]         pending_count;
  logic                  err_orphan_rdv;

  sdram_port_arbiter #(
    .NUM_MASTERS(NM), .IADDR(IADDR), .OADDR(OADDR), .MAX_PENDING(MAXP), .IDW(IDW)
  ) dut (
    .clk_sys(clk_sys), .rst(rst),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest),
    .sdram_address(sdram_address), .sdram_byteenable(sdram_byteenable),
    .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid), .sdram_waitrequest(sdram_waitrequest),
    .pending_count(pending_count), .err_orphan_rdv(err_orphan_rdv)
  );

  typedef struct {
    bit          act;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mcmd_t;

  typedef struct {
    logic [NM-1:0] wait_v;
    int            pcnt;
    bit            err;
    bit            cmd_exp;
    bit            ret_exp;
  } cyc_t;

  typedef struct {
    logic [OADDR-1:0] addr;
    logic [3:0]       be;
    logic [31:0]      wd;
    bit               rd;
    bit               wr;
  } exp_cmd_t;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_ret_t;

  cyc_t     cyc_q[$];
  exp_cmd_t cmd_q[$];
  exp_ret_t ret_q[$];

  mcmd_t mst [NM];
  int    last_grant;
  bit    locked;
  int    lock_id;
  int    id_fifo[$];
  bit    err_model;

  int vectors;
  int miscompares;

  // Free-running system clock.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic compareField(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive masters and controller, then advance the reference model.
  task automatic applyStimulus(input bit do_rst, input bit allow_new, input int ret_pct,
                               input int stall_pct, input bit force_rdv);
    cyc_t        rec;
    exp_cmd_t    ec;
    exp_ret_t    er;
    bit          waitreq;
    bit          ret;
    logic [31:0] rdata;
    int          sel;
    int          c;
    int          t;
    bit          is_rd;
    bit          blocked;

    @(posedge clk_sys);
    #1;
    for (int i = 0; i < NM; i++) begin
      if (do_rst) begin
        mst[i].act = 1'b0;
      end else if (allow_new && !mst[i].act && $urandom_range(0, 99) < 50) begin
        t = $urandom_range(0, 9);
        mst[i].act  = 1'b1;
        mst[i].wr   = (t < 4);
        mst[i].rd   = (t >= 4) || (t == 0);
        mst[i].addr = $urandom;
        mst[i].be   = 4'($urandom_range(1, 15));
        mst[i].wd   = $urandom;
      end
    end
    waitreq = !do_rst && ($urandom_range(0, 99) < stall_pct);
    ret     = !do_rst && (force_rdv || (id_fifo.size() > 0 && $urandom_range(0, 99) < ret_pct));
    rdata   = $urandom;

    rst = do_rst;
    for (int i = 0; i < NM; i++) begin
      m_address[i*IADDR +: IADDR] = mst[i].act ? mst[i].addr : 32'h0;
      m_byteenable[i*4 +: 4]      = mst[i].act ? mst[i].be : 4'h0;
      m_writedata[i*32 +: 32]     = mst[i].act ? mst[i].wd : 32'h0;
      m_read[i]                   = mst[i].act & mst[i].rd;
      m_write[i]                  = mst[i].act & mst[i].wr;
    end
    sdram_waitrequest   = waitreq;
    sdram_readdatavalid = ret;
    sdram_readdata      = rdata;

    rec.wait_v  = '1;
    rec.pcnt    = id_fifo.size();
    rec.err     = err_model;
    rec.cmd_exp = 1'b0;
    rec.ret_exp = 1'b0;

    if (do_rst) begin
      cyc_q.push_back(rec);
      id_fifo.delete();
      last_grant = NM - 1;
      locked     = 1'b0;
      err_model  = 1'b0;
      return;
    end

    sel = -1;
    if (locked) begin
      if (mst[lock_id].act) sel = lock_id;
      else locked = 1'b0;
    end else begin
      for (int k = 1; k <= NM; k++) begin
        c = (last_grant + k) % NM;
        if (sel < 0 && mst[c].act) sel = c;
      end
    end

    blocked = 1'b0;
    is_rd   = 1'b0;
    if (sel >= 0) begin
      is_rd   = !mst[sel].wr;
      blocked = is_rd && (id_fifo.size() == MAXP);
      rec.wait_v[sel] = waitreq || blocked;
      if (!blocked) begin
        rec.cmd_exp = 1'b1;
        ec.addr = OADDR'(mst[sel].addr >> 2);
        ec.be   = mst[sel].be;
        ec.wd   = mst[sel].wd;
        ec.rd   = is_rd;
        ec.wr   = !is_rd;
        cmd_q.push_back(ec);
      end
    end

    if (ret) begin
      if (id_fifo.size() > 0) begin
        er.id   = id_fifo.pop_front();
        er.data = rdata;
        ret_q.push_back(er);
        rec.ret_exp = 1'b1;
      end else begin
        err_model = 1'b1;
      end
    end

    if (sel >= 0 && !blocked) begin
      if (!waitreq) begin
        last_grant = sel;
        locked     = 1'b0;
        if (is_rd) id_fifo.push_back(sel);
        mst[sel].act = 1'b0;
      end else begin
        locked  = 1'b1;
        lock_id = sel;
      end
    end
    cyc_q.push_back(rec);
  endtask

  // Compare one cycle of DUT outputs against the oldest pending expectation.
  task automatic checkOutput();
    cyc_t          rec;
    exp_cmd_t      ec;
    exp_ret_t      er;
    logic [NM-1:0] exp_v;
    logic [NM*32-1:0] exp_d;
    bit            cmd_seen;
    bit            ret_seen;

    rec = cyc_q.pop_front();
    compareField("waitrequest", 128'(m_waitrequest), 128'(rec.wait_v));
    compareField("pending_count", 128'(pending_count), 128'(rec.pcnt));
    compareField("err_orphan_rdv", 128'(err_orphan_rdv), 128'(rec.err));

    cmd_seen = sdram_read | sdram_write;
    compareField("cmd_present", 128'(cmd_seen), 128'(rec.cmd_exp));
    if (cmd_seen || rec.cmd_exp) begin
      if (cmd_q.size() == 0) begin
        compareField("cmd_queue_nonempty", 128'(0), 128'(1));
      end else begin
        ec = cmd_q.pop_front();
        if (cmd_seen && rec.cmd_exp) begin
          compareField("sdram_address", 128'(sdram_address), 128'(ec.addr));
          compareField("sdram_byteenable", 128'(sdram_byteenable), 128'(ec.be));
          compareField("sdram_read", 128'(sdram_read), 128'(ec.rd));
          compareField("sdram_write", 128'(sdram_write), 128'(ec.wr));
          if (ec.wr) compareField("sdram_writedata", 128'(sdram_writedata), 128'(ec.wd));
        end
      end
    end

    ret_seen = |m_readdatavalid;
    compareField("readdatavalid_present", 128'(ret_seen), 128'(rec.ret_exp));
    if (ret_seen || rec.ret_exp) begin
      if (ret_q.size() == 0) begin
        compareField("return_queue_nonempty", 128'(0), 128'(1));
      end else begin
        er = ret_q.pop_front();
        if (ret_seen && rec.ret_exp) begin
          exp_v = '0;
          exp_v[er.id] = 1'b1;
          exp_d = '0;
          exp_d[er.id*32 +: 32] = er.data;
          compareField("m_readdatavalid", 128'(m_readdatavalid), 128'(exp_v));
          compareField("m_readdata", 128'(m_readdata), 128'(exp_d));
        end
      end
    end
  endtask

  // Monitor: checks every cycle once the driver has posted an expectation.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (cyc_q.size() > 0) checkOutput();
    end
  end

  // Driver: reset, randomized traffic with fill/drain phases, then a mid-flight reset.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    m_address = '0; m_byteenable = '0; m_read = '0; m_write = '0; m_writedata = '0;
    sdram_readdata = '0; sdram_readdatavalid = 1'b0; sdram_waitrequest = 1'b0;
    for (int i = 0; i < NM; i++) mst[i].act = 1'b0;
    last_grant = NM - 1;
    locked     = 1'b0;
    lock_id    = 0;
    err_model  = 1'b0;

    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      if (((c / 250) % 2) == 0) applyStimulus(1'b0, 1'b1, 5, 25, 1'b0);
      else                      applyStimulus(1'b0, 1'b1, 60, 25, 1'b0);
    end

    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 1'b1, 0, 20, 1'b0);
    if (id_fifo.size() < 2) $display("[TB] note: only %0d reads pending before reset", id_fifo.size());

    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);

    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    sdram_readdatavalid = 1'b0;
    @(negedge clk_sys);
    #1;
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
